// File: rtl/aes_pkg.sv
// Shared AES datapath definitions.
//   state_t   : one 128-bit AES state, byte 0 in bits [127:120].
//   sr_mode_e : ShiftRows mode selector (forward, inverse, bypass).
//   sr_perm   : ShiftRows / InvShiftRows byte permutation of one state.
package aes_pkg;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    SR_FWD = 2'b00,
    SR_INV = 2'b01,
    SR_BYP = 2'b10
  } sr_mode_e;

  // Byte b lives at bits [127-8b -: 8] with row r = b % 4 and column c = b / 4.
  // Forward rotates row r left by r columns; inverse rotates it right by r.
  // The 2-bit source column wraps modulo 4 on its own.
  function automatic state_t sr_perm(state_t s, logic inv);
    state_t     o;
    logic [1:0] src_c;
    o = s;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) begin
          src_c = 2'(c - r);
        end else begin
          src_c = 2'(c + r);
        end
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * int'(src_c)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_pipe_stage.sv
// One valid/ready register slice with a W-bit payload.
//   clk, reset           : clock and synchronous active-high reset.
//   in_valid / in_ready  : upstream handshake, in_data captured on transfer.
//   out_valid / out_ready: downstream handshake, out_data held until taken.
// in_ready depends only on the local valid flop and out_ready, so no
// combinational valid-to-ready path is created through the slice.
module aes_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next-state: advance when empty or when the consumer takes the held beat.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      // Payload only loads on a real transfer, so an undriven bus is never captured.
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Slice register; reset discards any held beat and zeroes the payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows / bypass unit for LANES AES states.
//   clk, reset            : clock, synchronous active-high reset.
//   in_valid/in_ready     : input handshake; in_mode, in_tag, in_state payload.
//   out_valid/out_ready   : output handshake; out_mode, out_tag, out_state payload.
//   occupancy             : number of stages currently holding a beat.
// The permutation is applied combinationally ahead of stage 1; the remaining
// stages only carry {mode, tag, state}.
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_mode,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic [128*LANES-1:0]         in_state,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_mode,
  output logic [TAG_W-1:0]             out_tag,
  output logic [128*LANES-1:0]         out_state,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int SW    = 128 * LANES;
  localparam int PW    = 2 + TAG_W + SW;
  localparam int OCC_W = $clog2(STAGES + 1);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("aes_shift_rows_pipe: STAGES must lie in 1..8");
  end

  logic [SW-1:0] perm_state;

  // Apply the beat's mode to every lane; both reserved codes pass data through.
  always_comb begin
    perm_state = in_state;
    for (int k = 0; k < LANES; k++) begin
      case (in_mode)
        SR_FWD:  perm_state[128 * k +: 128] = sr_perm(in_state[128 * k +: 128], 1'b0);
        SR_INV:  perm_state[128 * k +: 128] = sr_perm(in_state[128 * k +: 128], 1'b1);
        default: perm_state[128 * k +: 128] = in_state[128 * k +: 128];
      endcase
    end
  end

  // Link k feeds stage k+1; link 0 is the unit input, link STAGES the output.
  logic          link_valid [0:STAGES];
  logic          link_ready [0:STAGES];
  logic [PW-1:0] link_data  [0:STAGES];

  assign link_valid[0]      = in_valid;
  assign link_data[0]       = {in_mode, in_tag, perm_state};
  assign link_ready[STAGES] = out_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    aes_pipe_stage #(
      .W (PW)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (link_valid[g]),
      .in_ready  (link_ready[g]),
      .in_data   (link_data[g]),
      .out_valid (link_valid[g+1]),
      .out_ready (link_ready[g+1]),
      .out_data  (link_data[g+1])
    );
  end

  // Ready is forced low during reset so no input transfer can be counted.
  assign in_ready  = link_ready[0] && !reset;
  assign out_valid = link_valid[STAGES];
  assign {out_mode, out_tag, out_state} = link_data[STAGES];

  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Occupancy moves only when exactly one side of the pipe transfers.
  always_comb begin
    occ_d = occ_q;
    if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_W'(1'b1);
    end else if (out_fire && !in_fire) begin
      occ_d = occ_q - OCC_W'(1'b1);
    end else begin
      occ_d = occ_q;
    end
  end

  // Occupancy counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= {OCC_W{1'b0}};
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: doc/aes_shift_rows_pipe.md
Name: aes_shift_rows_pipe

Overview:
Parametrised, pipelined ShiftRows unit for the AES datapath.
- Applies forward ShiftRows, InvShiftRows or bypass, selected per transaction, to LANES independent 128-bit states per beat.
- Sits between SubBytes/InvSubBytes and MixColumns/InvMixColumns in the round datapath.
- Uses valid/ready flow control with a configurable register depth, so it can balance round timing and absorb back-pressure.

Parameters:
LANES, 1, number of 128-bit states processed per beat.
STAGES, 2, register stages from input to output; legal range 1..8 (elaboration error otherwise).
TAG_W, 4, width of the sideband tag carried alongside each beat.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  input beat valid.
in_ready  output  1  unit accepts a beat this cycle.
in_mode  input  2  00 forward ShiftRows, 01 InvShiftRows, 10/11 bypass.
in_tag  input  TAG_W  sideband, returned unchanged with the beat.
in_state  input  128*LANES  lane k occupies bits [128k+127:128k].
out_valid  output  1  output beat valid.
out_ready  input  1  downstream accepts.
out_mode  output  2  mode the beat was processed with.
out_tag  output  TAG_W  tag of the output beat.
out_state  output  128*LANES  transformed states.
occupancy  output  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- Byte numbering within a lane:
  - byte b sits at bits [127-8b : 120-8b].
  - row r = b mod 4, column c = b div 4 (column-major AES state).
- Forward: out byte (r + 4c) = in byte (r + 4((c + r) mod 4)).
- Inverse: out byte (r + 4c) = in byte (r + 4((c - r) mod 4)).
- Bypass: out = in.
- Row 0 is never moved. Lanes are independent and all use the beat's mode.
- The permutation is combinational on the input and is captured into stage 1. Stages 2..STAGES are pure registers.
- Each stage holds: valid, mode, tag, state.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Stage i advances when it is empty or stage i+1 can accept. The last stage advances when out_ready is high.
  - in_ready = !stage1.valid || stage1 advances. This is a combinational ready chain; no combinational valid→ready path inside the unit.
  - Once out_valid is asserted, out_state, out_mode and out_tag hold stable until the transfer. Same for the input contract: the upstream holds its data until accepted.
- Latency: a beat accepted at edge N appears on out_valid after edge N+STAGES-1, i.e. it is visible STAGES cycles after acceptance when unstalled.
- Throughput: one beat per cycle with out_ready held high. No bubbles are inserted.
- Full: all stages valid and out_ready low → in_ready low; no data is overwritten.
- Simultaneous push and pop when full: allowed; occupancy is unchanged.
- Empty with in_valid high and out_ready low: the beat enters and occupancy increments.
- occupancy: +1 on input transfer only, -1 on output transfer only, unchanged when both or neither occur. Range 0..STAGES.
- Reset (including mid-stream):
  - All stage valids clear next edge. In-flight beats are discarded.
  - out_valid=0, occupancy=0, out_state/out_tag/out_mode=0.
  - in_ready reads 1 in the first cycle after reset deasserts.
  - While reset is high, in_ready=0 and no transfer is recorded.
- X on in_state when in_valid=0 must not propagate into valid or occupancy.

Decomposition:
- Shared package aes_pkg holds:
  - typedef state_t (logic [127:0]).
  - typedef enum sr_mode_e {SR_FWD=2'b00, SR_INV=2'b01, SR_BYP=2'b10}.
  - function sr_perm(state_t s, logic inv) returning the permuted state.
- One sub-module, aes_pipe_stage: a single valid/ready register slice parametrised on payload width, instantiated STAGES times via generate. The permutation stays in the top level.

Test Plan:
- Forward, LANES=1, STAGES=2, FIPS-197 round-1 vector: in_state=d42711aee0bf98f1b8b45de51e415230, mode 00 → out_state=d4bf5d30e0b452aeb84111f11e2798e5 two cycles after acceptance; tag preserved.
- Inverse of that output, mode 01 → d42711aee0bf98f1b8b45de51e415230. Bypass, modes 10 and 11 → input unchanged.
- LANES=2, lane0 forward vector and lane1=000102…0f, mode 00 → lane1=00050a0f04090e03080d02070c01060b; lane0 as in the first scenario.
- Back-pressure, STAGES=3: stream 5 beats with out_ready low → in_ready drops after 3 accepted, occupancy=3. Raise out_ready → beats emerge in order with tags 0..4 and no loss or duplication.
- Full simultaneous push/pop: with the pipe full and in_valid=out_ready=1 for 10 cycles → one beat per cycle and occupancy stays at STAGES.
- Reset asserted mid-stream with 2 beats in flight → next cycle out_valid=0 and occupancy=0; after release, the first new beat returns with the correct transform and no stale data.
